// File: rtl/lsu2apb_pkg.sv
// Shared types and constants for the LSU-to-APB bridge.
package lsu2apb_pkg;

  // Bridge control states; the encoding is also exported on the debug port.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    RESP   = 2'd3
  } state_e;

  // Only full-word writes are forwarded to APB.
  localparam logic [3:0] BE_FULL = 4'b1111;

endpackage

// File: rtl/apb_bus.sv
// APB3 bus bundle with initiator and target views.
interface APB_BUS #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32
);
  logic [ADDR_WIDTH-1:0] paddr;
  logic [DATA_WIDTH-1:0] pwdata;
  logic                  pwrite;
  logic                  psel;
  logic                  penable;
  logic [DATA_WIDTH-1:0] prdata;
  logic                  pready;
  logic                  pslverr;

  modport Master (
    output paddr, pwdata, pwrite, psel, penable,
    input  prdata, pready, pslverr
  );

  modport Slave (
    input  paddr, pwdata, pwrite, psel, penable,
    output prdata, pready, pslverr
  );
endinterface

// File: rtl/lsu2apb_master.sv
// Bridges a core load/store request port onto an APB3 initiator.
//
// Core handshake: a request is accepted (granted) in any cycle where both
// req_i and gnt_o are high; the request inputs are sampled only in that
// cycle. Each granted request produces exactly one rvalid_o pulse later,
// with rdata_o/err_o valid only while rvalid_o is high. gnt_o can only be
// high while the bridge is IDLE or presenting a response, so at most one
// request is outstanding.
module lsu2apb_master
  import lsu2apb_pkg::*;
#(
  parameter int unsigned APB_ADDR_WIDTH = 32,
  parameter int unsigned APB_DATA_WIDTH = 32,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic                      req_i,
  output logic                      gnt_o,
  input  logic                      we_i,
  input  logic [3:0]                be_i,
  input  logic [APB_ADDR_WIDTH-1:0] addr_i,
  input  logic [APB_DATA_WIDTH-1:0] wdata_i,
  output logic                      rvalid_o,
  output logic [APB_DATA_WIDTH-1:0] rdata_o,
  output logic                      err_o,
  output logic [1:0]                state_dbg_o,
  APB_BUS.Master                    apb_master
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYCLES - 1);

  state_e                    state_q, state_d;
  logic [CNT_W-1:0]          cnt_q, cnt_d;
  logic                      psel_q, psel_d;
  logic                      penable_q, penable_d;
  logic                      pwrite_q, pwrite_d;
  logic [APB_ADDR_WIDTH-1:0] paddr_q, paddr_d;
  logic [APB_DATA_WIDTH-1:0] pwdata_q, pwdata_d;
  logic                      rvalid_q, rvalid_d;
  logic [APB_DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic                      err_q, err_d;
  logic                      gnt_c;

  // The low address bits are dropped: APB accesses are always word aligned.
  logic unused_addr_lsbs;
  assign unused_addr_lsbs = ^addr_i[1:0];

  // Next-state, grant and latched transfer/response values.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    pwrite_d = pwrite_q;
    paddr_d  = paddr_q;
    pwdata_d = pwdata_q;
    rdata_d  = rdata_q;
    err_d    = err_q;
    gnt_c    = 1'b0;

    case (state_q)
      IDLE, RESP: begin
        gnt_c   = req_i;
        state_d = IDLE;
        if (req_i) begin
          pwrite_d = we_i;
          pwdata_d = wdata_i;
          paddr_d  = {addr_i[APB_ADDR_WIDTH-1:2], 2'b00};
          if (we_i && (be_i != BE_FULL)) begin
            // Sub-word writes cannot be expressed on APB3: reject locally.
            state_d = RESP;
            rdata_d = '0;
            err_d   = 1'b1;
          end else begin
            state_d = SETUP;
          end
        end
      end
      SETUP: begin
        state_d = ACCESS;
        cnt_d   = '0;
      end
      ACCESS: begin
        // pready is checked first so a completion on the last allowed
        // cycle is reported normally rather than as a timeout.
        if (apb_master.pready) begin
          state_d = RESP;
          rdata_d = pwrite_q ? '0 : apb_master.prdata;
          err_d   = apb_master.pslverr;
        end else if (cnt_q == CNT_MAX) begin
          state_d = RESP;
          rdata_d = '0;
          err_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    psel_d    = (state_d == SETUP) || (state_d == ACCESS);
    penable_d = (state_d == ACCESS);
    rvalid_d  = (state_d == RESP);
  end

  // State and registered outputs, cleared by the synchronous reset.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      psel_q    <= 1'b0;
      penable_q <= 1'b0;
      pwrite_q  <= 1'b0;
      paddr_q   <= '0;
      pwdata_q  <= '0;
      rvalid_q  <= 1'b0;
      rdata_q   <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      psel_q    <= psel_d;
      penable_q <= penable_d;
      pwrite_q  <= pwrite_d;
      paddr_q   <= paddr_d;
      pwdata_q  <= pwdata_d;
      rvalid_q  <= rvalid_d;
      rdata_q   <= rdata_d;
      err_q     <= err_d;
    end
  end

  assign gnt_o              = gnt_c & rst_ni;
  assign rvalid_o           = rvalid_q;
  assign rdata_o            = rdata_q;
  assign err_o              = err_q;
  assign state_dbg_o        = state_q;
  assign apb_master.psel    = psel_q;
  assign apb_master.penable = penable_q;
  assign apb_master.pwrite  = pwrite_q;
  assign apb_master.paddr   = paddr_q;
  assign apb_master.pwdata  = pwdata_q;

endmodule

// File: tb/tb_lsu2apb_master.sv
// Self-checking bench for lsu2apb_master (built with a 4-cycle timeout).
module tb_lsu2apb_master;
  import lsu2apb_pkg::*;

  localparam int T = 4;

  // ---------------- clock / reset / signals ----------------
  logic        clk = 1'b0;
  logic        rst_ni;
  logic        req_i, we_i;
  logic [3:0]  be_i;
  logic [31:0] addr_i, wdata_i;
  logic        gnt_o, rvalid_o, err_o;
  logic [31:0] rdata_o;
  logic [1:0]  state_dbg_o;

  always #5 clk = ~clk;

  APB_BUS #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) apb ();

  lsu2apb_master #(
    .APB_ADDR_WIDTH(32),
    .APB_DATA_WIDTH(32),
    .TIMEOUT_CYCLES(T)
  ) dut (
    .clk_i      (clk),
    .rst_ni     (rst_ni),
    .req_i      (req_i),
    .gnt_o      (gnt_o),
    .we_i       (we_i),
    .be_i       (be_i),
    .addr_i     (addr_i),
    .wdata_i    (wdata_i),
    .rvalid_o   (rvalid_o),
    .rdata_o    (rdata_o),
    .err_o      (err_o),
    .state_dbg_o(state_dbg_o),
    .apb_master (apb)
  );

  // ---------------- APB target model ----------------
  // Answers with pready after cfg_waits wait states.
  int          cfg_waits = 0;
  logic [31:0] cfg_prdata = '0;
  logic        cfg_slverr = 1'b0;
  int          acc_cnt = 0;

  always @(posedge clk) begin
    if (!apb.psel) acc_cnt <= 0;
    else if (apb.penable) acc_cnt <= acc_cnt + 1;
  end

  assign apb.pready  = apb.psel && apb.penable && (acc_cnt == cfg_waits);
  assign apb.prdata  = cfg_prdata;
  assign apb.pslverr = cfg_slverr;

  // ---------------- scoreboard ----------------
  int n_chk = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    int          lat;
    logic [31:0] rdata;
    logic        err;
    int          acc;
  } exp_t;

  function automatic exp_t model(input logic we, input logic [3:0] be, input int waits,
                                 input logic [31:0] prdata, input logic slverr);
    exp_t e;
    if (we && be != 4'hF) begin
      e.lat = 1; e.rdata = '0; e.err = 1'b1; e.acc = 0;
    end else if (waits < T) begin
      e.lat = 3 + waits; e.rdata = we ? 32'h0 : prdata; e.err = slverr; e.acc = waits + 1;
    end else begin
      e.lat = 2 + T; e.rdata = '0; e.err = 1'b1; e.acc = T;
    end
    return e;
  endfunction

  // ---------------- driver ----------------
  // Called one step after a clock edge with the bridge idle.
  task automatic run_txn(input string name, input logic we, input logic [3:0] be,
                         input logic [31:0] addr, input logic [31:0] wdata, input int waits,
                         input logic [31:0] prdata, input logic slverr, input int exp_lat,
                         input logic [31:0] exp_rdata, input logic exp_err, input int exp_acc);
    logic [31:0] exp_paddr;
    int cyc, psel_n, acc_n, bus_bad;
    logic seen;
    exp_paddr = {addr[31:2], 2'b00};
    cfg_waits = waits; cfg_prdata = prdata; cfg_slverr = slverr;
    req_i = 1'b1; we_i = we; be_i = be; addr_i = addr; wdata_i = wdata;
    #1;
    check({name, ".gnt"}, 32'(gnt_o), 32'd1);
    @(posedge clk); #1;
    req_i = 1'b0; we_i = $urandom_range(0, 1); be_i = 4'($urandom); addr_i = $urandom; wdata_i = $urandom;
    seen = 1'b0; psel_n = 0; acc_n = 0; bus_bad = 0; cyc = 1;
    for (int i = 1; i < 40; i++) begin
      cyc = i;
      if (apb.psel) begin
        psel_n++;
        if (apb.penable) acc_n++;
        if (apb.paddr !== exp_paddr || apb.pwrite !== we || (we && apb.pwdata !== wdata)) bus_bad++;
      end
      if (rvalid_o) begin
        seen = 1'b1;
        break;
      end
      @(posedge clk); #1;
    end
    check({name, ".rvalid_seen"}, 32'(seen), 32'd1);
    check({name, ".latency"}, 32'(cyc), 32'(exp_lat));
    check({name, ".rdata"}, rdata_o, exp_rdata);
    check({name, ".err"}, 32'(err_o), 32'(exp_err));
    check({name, ".psel_cycles"}, 32'(psel_n), (exp_acc == 0) ? 32'd0 : 32'(exp_acc + 1));
    check({name, ".access_cycles"}, 32'(acc_n), 32'(exp_acc));
    check({name, ".bus_fields"}, 32'(bus_bad), 32'd0);
    @(posedge clk); #1;
    check({name, ".rvalid_drop"}, 32'(rvalid_o), 32'd0);
    check({name, ".psel_after"}, 32'(apb.psel), 32'd0);
    if (exp_acc != 0) check({name, ".paddr_hold"}, apb.paddr, exp_paddr);
  endtask

  // ---------------- directed vectors ----------------
  typedef struct {
    string       name;
    logic        we;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          waits;
    logic [31:0] prdata;
    logic        slverr;
    int          exp_lat;
    logic [31:0] exp_rdata;
    logic        exp_err;
    int          exp_acc;
  } vec_t;

  vec_t vecs[7];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t e;
    int gcnt, rvcnt, overlap, rd_bad, n_rv;
    int rv_cyc[3];
    logic we_r;
    logic [3:0] be_r;

    vecs[0] = '{"rd_nowait",   1'b0, 4'hF, 32'h1A10_0007, 32'h0,         0,  32'hCAFE_F00D, 1'b0, 3, 32'hCAFE_F00D, 1'b0, 1};
    vecs[1] = '{"wr_2wait_err",1'b1, 4'hF, 32'h4000_0012, 32'h1234_5678, 2,  32'h7777_7777, 1'b1, 5, 32'h0,         1'b1, 3};
    vecs[2] = '{"wr_partial",  1'b1, 4'b0011, 32'h4000_0020, 32'hAAAA_BBBB, 0, 32'h0,       1'b0, 1, 32'h0,         1'b1, 0};
    vecs[3] = '{"rd_timeout",  1'b0, 4'hF, 32'h0000_0100, 32'h0,         99, 32'hDEAD_BEEF, 1'b0, 6, 32'h0,         1'b1, 4};
    vecs[4] = '{"rd_pready_at_limit", 1'b0, 4'hF, 32'h0000_0203, 32'h0,  3,  32'h5555_AAAA, 1'b0, 6, 32'h5555_AAAA, 1'b0, 4};
    vecs[5] = '{"rd_be0_full", 1'b0, 4'h0, 32'h8000_0001, 32'h0,         1,  32'h0BAD_F00D, 1'b1, 4, 32'h0BAD_F00D, 1'b1, 2};
    vecs[6] = '{"wr_ok",       1'b1, 4'hF, 32'h0000_0FFC, 32'hFEED_0001, 0,  32'h3333_3333, 1'b0, 3, 32'h0,         1'b0, 1};

    // Reset: hold with a pending request, outputs must be cleared.
    rst_ni = 1'b0; req_i = 1'b1; we_i = 1'b1; be_i = 4'hF;
    addr_i = 32'h1234_5678; wdata_i = 32'h9ABC_DEF0;
    repeat (3) @(posedge clk);
    #1;
    check("rst.gnt", 32'(gnt_o), 32'd0);
    check("rst.rvalid", 32'(rvalid_o), 32'd0);
    check("rst.rdata", rdata_o, 32'd0);
    check("rst.err", 32'(err_o), 32'd0);
    check("rst.psel", 32'(apb.psel), 32'd0);
    check("rst.penable", 32'(apb.penable), 32'd0);
    check("rst.pwrite", 32'(apb.pwrite), 32'd0);
    check("rst.paddr", apb.paddr, 32'd0);
    check("rst.pwdata", apb.pwdata, 32'd0);
    check("rst.state", 32'(state_dbg_o), 32'(IDLE));
    req_i = 1'b0; rst_ni = 1'b1;
    @(posedge clk); #1;

    // Table-driven directed transfers.
    foreach (vecs[i])
      run_txn(vecs[i].name, vecs[i].we, vecs[i].be, vecs[i].addr, vecs[i].wdata, vecs[i].waits,
              vecs[i].prdata, vecs[i].slverr, vecs[i].exp_lat, vecs[i].exp_rdata,
              vecs[i].exp_err, vecs[i].exp_acc);

    // Back-to-back reads with req_i held until three grants are taken.
    cfg_waits = 0; cfg_prdata = 32'h600D_0B2B; cfg_slverr = 1'b0;
    we_i = 1'b0; be_i = 4'hF; addr_i = 32'h0000_0040;
    gcnt = 0; rvcnt = 0; overlap = 0; rd_bad = 0;
    rv_cyc[0] = -1; rv_cyc[1] = -1; rv_cyc[2] = -1;
    for (int c = 0; c < 14; c++) begin
      req_i = (gcnt < 3);
      #1;
      if (rvalid_o) begin
        if (rvcnt < 3) rv_cyc[rvcnt] = c;
        rvcnt++;
        if (rdata_o !== 32'h600D_0B2B || err_o !== 1'b0) rd_bad++;
        if (gnt_o) overlap++;
      end
      if (gnt_o) gcnt++;
      @(posedge clk); #1;
    end
    req_i = 1'b0;
    check("b2b.grants", 32'(gcnt), 32'd3);
    check("b2b.rvalids", 32'(rvcnt), 32'd3);
    check("b2b.rv0_cycle", 32'(rv_cyc[0]), 32'd3);
    check("b2b.rv1_cycle", 32'(rv_cyc[1]), 32'd6);
    check("b2b.rv2_cycle", 32'(rv_cyc[2]), 32'd9);
    check("b2b.gnt_in_resp", 32'(overlap), 32'd2);
    check("b2b.rdata", 32'(rd_bad), 32'd0);

    // Reset during a stalled ACCESS phase.
    cfg_waits = 99;
    req_i = 1'b1; we_i = 1'b0; be_i = 4'hF; addr_i = 32'h2000_0008;
    @(posedge clk); #1;
    req_i = 1'b0;
    @(posedge clk); #1;
    check("rstmid.in_access", 32'(apb.penable), 32'd1);
    @(posedge clk); #1;
    rst_ni = 1'b0;
    @(posedge clk); #1;
    rst_ni = 1'b1;
    check("rstmid.psel", 32'(apb.psel), 32'd0);
    check("rstmid.rvalid", 32'(rvalid_o), 32'd0);
    n_rv = 0;
    for (int c = 0; c < 8; c++) begin
      if (rvalid_o) n_rv++;
      @(posedge clk); #1;
    end
    check("rstmid.no_rvalid", 32'(n_rv), 32'd0);
    run_txn("rstmid.recover", 1'b0, 4'hF, 32'h2000_0008, 32'h0, 0, 32'h0102_0304, 1'b0,
            3, 32'h0102_0304, 1'b0, 1);

    // Randomized transfers checked against the model.
    for (int i = 0; i < 40; i++) begin
      logic [31:0] a, wd, pd;
      int w;
      logic s;
      we_r = 1'($urandom_range(0, 1));
      be_r = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 14)) : 4'hF;
      a = $urandom; wd = $urandom; pd = $urandom;
      w = $urandom_range(0, 6);
      s = 1'($urandom_range(0, 1));
      e = model(we_r, be_r, w, pd, s);
      run_txn($sformatf("rnd%0d", i), we_r, be_r, a, wd, w, pd, s, e.lat, e.rdata, e.err, e.acc);
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk); #1;
      end
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/lsu2apb_master.md
LSU2APB_MASTER -- requirements
Module: lsu2apb_master

Interface
REQ-001 SHALL have parameter APB_ADDR_WIDTH, default 32: APB address width.
REQ-002 SHALL have parameter APB_DATA_WIDTH, default 32: APB and core data width.
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 255: maximum ACCESS-phase cycles before forced abort; legal range 1..65535.
REQ-004 SHALL have one clock and a synchronous active-low reset: clk_i input 1, the single clock, all logic rising-edge; rst_ni input 1, synchronous active-low reset.
REQ-005 SHALL have ports:
- req_i  input  1  core request.
- gnt_o  output  1  request accepted this cycle.
- we_i  input  1  1 = write, 0 = read.
- be_i  input  4  byte enables.
- addr_i  input  APB_ADDR_WIDTH  byte address.
- wdata_i  input  APB_DATA_WIDTH  write data.
- rvalid_o  output  1  response valid, one cycle per granted request.
- rdata_o  output  APB_DATA_WIDTH  read data, qualified by rvalid_o.
- err_o  output  1  error flag, qualified by rvalid_o.
- apb_master  APB_BUS.Master  (paddr, pwdata, pwrite, psel, penable out; prdata, pready, pslverr in)  APB3 initiator port.

Function
REQ-006 SHALL implement FSM states IDLE, SETUP, ACCESS, RESP.
REQ-007 SHALL drive gnt_o = req_i when state is IDLE or RESP, else 0; this is the only combinational output.
REQ-008 On grant, SHALL latch we_i, wdata_i, paddr = {addr_i[APB_ADDR_WIDTH-1:2],2'b00}, and go to SETUP; the latched values stay stable until the transfer ends.
REQ-009 A granted write with be_i != 4'b1111 SHALL issue no APB transfer; it SHALL go directly to RESP with err_o=1 and rdata_o=0.
REQ-010 Reads SHALL always be full-word transfers, whatever be_i is.
REQ-011 SETUP SHALL last exactly one cycle with psel=1, penable=0, then go to ACCESS.
REQ-012 ACCESS SHALL hold psel=1, penable=1 until pready=1. Then it SHALL capture prdata (reads only, writes give 0) into rdata_o and pslverr into err_o, and go to RESP.
REQ-013 An ACCESS cycle counter SHALL reset to 0 on entry to ACCESS. If the counter reaches TIMEOUT_CYCLES-1 with pready=0, the block SHALL abort: go to RESP with err_o=1, rdata_o=0, and psel/penable low in the next cycle.
REQ-014 RESP SHALL assert rvalid_o for exactly one cycle.
REQ-015 In RESP, the next state SHALL be SETUP if a new request is granted, else IDLE. Back-to-back throughput is 1 transfer per 3 cycles with pready tied high.
REQ-016 psel and penable SHALL be 0 in IDLE and RESP.
REQ-017 pwrite, paddr and pwdata SHALL hold their last values outside transfers.
REQ-018 Latency from grant to rvalid_o SHALL be 3 cycles with zero APB wait states, plus one cycle per wait state.
REQ-019 If pready and the timeout limit coincide in the same cycle, pready SHALL win: the normal response is returned and no timeout error is raised.

Reset
REQ-020 While rst_ni=0 at a clock edge, the block SHALL set state=IDLE, psel=0, penable=0, pwrite=0, paddr=0, pwdata=0, rvalid_o=0, rdata_o=0, err_o=0, and counter=0.
REQ-021 gnt_o SHALL be 0 while rst_ni=0.
REQ-022 Reset mid-transfer SHALL abandon the transfer without asserting rvalid_o; psel SHALL be low in the cycle after reset is sampled.

Structure
REQ-023 A shared package lsu2apb_pkg SHALL hold the state enum and the full-word byte-enable constant 4'b1111.
REQ-024 The timeout counter SHALL be inlined; no sub-module is required.
REQ-025 The counter width SHALL be $clog2(TIMEOUT_CYCLES+1).

Verification
REQ-026 Read, pready high: req with addr 0x1A10_0007 -> paddr 0x1A10_0004; SETUP then ACCESS; prdata 0xCAFE_F00D -> rvalid_o 3 cycles after grant, rdata_o 0xCAFE_F00D, err_o 0.
REQ-027 Write, 2 wait states, pslverr=1 at completion: wdata 0x1234_5678, be 4'hF -> pwrite=1; rvalid_o 5 cycles after grant with err_o=1.
REQ-028 Partial write, be 4'b0011: no psel pulse; rvalid_o with err_o=1 on the cycle after grant.
REQ-029 Timeout, TIMEOUT_CYCLES=4, pready stuck low: exactly 4 ACCESS cycles, then rvalid_o with err_o=1 and rdata_o=0; psel low afterwards.
REQ-030 Back-to-back: req_i held high for 3 reads -> gnt_o asserted in the RESP cycles, 3 rvalid pulses spaced 3 cycles apart.
REQ-031 Reset in ACCESS: rst_ni low for 1 cycle during a stalled read -> no rvalid_o, psel=0 next cycle, next request completes normally.
